// File: rtl/softmax_stream.sv
// rtl/softmax_stream.sv - streaming Q.FRAC softmax with base-2 exponentials and a restoring divider
//
// Accepts an N-element signed vector one element per beat, computes
// 2^((x - max) * log2(e)) per element, sums them, and streams out
// N probabilities e_i * 2^FRAC / sum through a bit-serial divider.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready high only in IDLE/LOAD
//   in_x                signed input element, Q(DW-FRAC).FRAC
//   max_x               external maximum (only with SOFTMAX_EXT_MAX_EN)
//   out_valid/out_ready output handshake
//   out_prob            probability, Q.FRAC, 0..2^FRAC
//   out_last            marks the N-th probability
//   busy                high whenever the FSM is not in IDLE
//
// Build option: SOFTMAX_EXT_MAX_EN - take the vector maximum from max_x
// (sampled with the first beat) instead of tracking it internally.

module softmax_stream #(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int FRAC = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_x,
`ifdef SOFTMAX_EXT_MAX_EN
    input  logic [DW-1:0] max_x,
`endif
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_prob,
    output logic          out_last,
    output logic          busy
);

    localparam int IW = $clog2(N);
    localparam int SW = FRAC + 1 + $clog2(N);
    localparam int PW = DW + FRAC + 2;
    localparam int CW = $clog2(FRAC + 1);
    // log2(e) in Q.FRAC, rounded (5909 for FRAC = 12)
    localparam int L_CONST = $rtoi(1.4426950408889634 * (2.0 ** FRAC) + 0.5);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXP,
        S_DIV,
        S_OUT
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   bitcnt;
    logic [DW-1:0]   max_r;
    logic [SW-1:0]   sum_r;
    logic [SW:0]     rem_r;
    logic [FRAC:0]   quo_r;
    logic [DW-1:0]   buf_r [N];

    logic            in_accept;
    logic            idx_last;

    // exponential datapath
    logic [DW-1:0]        cur_x;
    logic signed [DW:0]   d_full;
    logic signed [DW-1:0] d_sat;
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] l_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] t_val;
    logic signed [PW-1:0] u_val;
    logic signed [PW-1:0] neg_u;
    logic [FRAC-1:0]      f_val;
    logic [FRAC:0]        e_val;

    // divider step
    logic            rem_ge;
    logic [SW:0]     rem_sub;
    logic [FRAC:0]   quo_next;

    assign in_accept = in_valid & in_ready;
    assign idx_last  = (idx == IW'(N - 1));

    always_comb begin
        cur_x  = buf_r[idx];
        d_full = {cur_x[DW-1], cur_x} - {max_r[DW-1], max_r};
        // clamp to [-2^(DW-1), 0]; positive only happens with an external max
        if (!d_full[DW])
            d_sat = '0;
        else if (!d_full[DW-1])
            d_sat = {1'b1, {(DW-1){1'b0}}};
        else
            d_sat = d_full[DW-1:0];
        d_ext = PW'(d_sat);
        l_ext = PW'(L_CONST);
        prod  = d_ext * l_ext;
        t_val = prod >>> FRAC;
        u_val = t_val >>> FRAC;
        f_val = t_val[FRAC-1:0];
        neg_u = -u_val;
        if (neg_u > PW'(FRAC + 1))
            e_val = '0;
        else
            e_val = {1'b1, f_val} >> neg_u;
    end

    always_comb begin
        rem_ge   = (rem_r >= {1'b0, sum_r});
        rem_sub  = rem_ge ? (rem_r - {1'b0, sum_r}) : rem_r;
        quo_next = {quo_r[FRAC-1:0], rem_ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            bitcnt    <= '0;
            max_r     <= '0;
            sum_r     <= '0;
            rem_r     <= '0;
            quo_r     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_prob  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < N; i++) buf_r[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_accept) begin
                        buf_r[0] <= in_x;
`ifdef SOFTMAX_EXT_MAX_EN
                        max_r    <= max_x;
`else
                        max_r    <= in_x;
`endif
                        idx      <= IW'(1);
                        sum_r    <= '0;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_accept) begin
                        buf_r[idx] <= in_x;
`ifdef SOFTMAX_EXT_MAX_EN
`else
                        if ($signed(in_x) > $signed(max_r)) max_r <= in_x;
`endif
                        if (idx_last) begin
                            idx      <= '0;
                            in_ready <= 1'b0;
                            state    <= S_EXP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                S_EXP: begin
                    // exponentials overwrite the inputs in place
                    buf_r[idx] <= DW'(e_val);
                    sum_r      <= sum_r + SW'(e_val);
                    if (idx_last) begin
                        idx    <= '0;
                        rem_r  <= (SW + 1)'(buf_r[0][FRAC:0]);
                        quo_r  <= '0;
                        bitcnt <= CW'(FRAC);
                        state  <= S_DIV;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                S_DIV: begin
                    // the dividend's low FRAC bits are zero, so each step shifts in 0
                    quo_r <= quo_next;
                    rem_r <= {rem_sub[SW-1:0], 1'b0};
                    if (bitcnt == '0) begin
                        out_valid <= 1'b1;
                        out_prob  <= DW'(quo_next);
                        out_last  <= idx_last;
                        state     <= S_OUT;
                    end else begin
                        bitcnt <= bitcnt - CW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (idx_last) begin
                            idx      <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            idx    <= idx + IW'(1);
                            rem_r  <= (SW + 1)'(buf_r[idx + IW'(1)][FRAC:0]);
                            quo_r  <= '0;
                            bitcnt <= CW'(FRAC);
                            state  <= S_DIV;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
